// File: rtl/bit_deserializer_pkg.sv
// Shared stream-stage constants: bit-order encodings for serial/parallel converters.
package bit_deserializer_pkg;

  localparam int unsigned ORDER_LSB_FIRST = 0;
  localparam int unsigned ORDER_MSB_FIRST = 1;

endpackage

// File: rtl/bit_deserializer_word_hold_reg.sv
// Output word register with valid flag; a load at the same edge as a consume wins.
module word_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             consume,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/bit_deserializer.sv
// Packs accepted serial bits into WIDTH-bit words presented on a valid/ready port.
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    fill_cnt
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] shifted;
  logic             last;
  logic             accept;
  logic             load;

  always_comb begin
    last      = (fill_q == CW'(WIDTH - 1));
    // Stall only the word-completing bit while the held word is still unconsumed.
    bit_ready = !(last && word_valid && !word_ready);
    accept    = bit_valid && bit_ready;
    if (MSB_FIRST == ORDER_MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, shift_q[WIDTH-1:1]};
    end

    shift_d = shift_q;
    fill_d  = fill_q;
    load    = 1'b0;
    if (clear) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (accept) begin
      if (last) begin
        load    = 1'b1;
        shift_d = '0;
        fill_d  = '0;
      end else begin
        shift_d = shifted;
        fill_d  = fill_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(shifted),
    .consume  (word_ready),
    .data_out (word_out),
    .valid_out(word_valid)
  );

  assign fill_cnt = fill_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed and randomized checks of bit_deserializer in MSB-first and LSB-first builds.
module tb_bit_deserializer;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       clear;
  logic       word_ready;

  logic       bit_ready_m, word_valid_m;
  logic [7:0] word_out_m;
  logic [2:0] fill_cnt_m;
  logic       bit_ready_l, word_valid_l;
  logic [7:0] word_out_l;
  logic [2:0] fill_cnt_l;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0]  tx;
  logic [7:0]  exp_q[$];
  int unsigned bidx;
  int unsigned consumed;
  int unsigned cycles;
  logic        m_wv;
  logic        m_rdy;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .clear(clear), .word_out(word_out_m),
    .word_valid(word_valid_m), .word_ready(word_ready), .fill_cnt(fill_cnt_m)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .clear(clear), .word_out(word_out_l),
    .word_valid(word_valid_l), .word_ready(word_ready), .fill_cnt(fill_cnt_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic drain();
    word_ready = 1'b1;
    bit_valid  = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; word_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_word_valid", word_valid_m, 1'b0);
    check("rst_word_out",   word_out_m,   8'h00);
    check("rst_fill_cnt",   fill_cnt_m,   3'd0);
    check("rst_bit_ready",  bit_ready_m,  1'b1);

    // Test 1/2: 1,0,1,1,0,0,1,0 -> B2 (MSB first) and 4D (LSB first)
    word_ready = 1'b1;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_bit(0); send_bit(0); send_bit(1);
    check("t1_fill7",       fill_cnt_m,   3'd7);
    check("t1_not_valid",   word_valid_m, 1'b0);
    send_bit(0);
    check("t1_valid",       word_valid_m, 1'b1);
    check("t1_word_msb",    word_out_m,   8'hB2);
    check("t2_word_lsb",    word_out_l,   8'h4D);
    check("t1_fill_wrap",   fill_cnt_m,   3'd0);
    drain();
    check("t1_consumed",    word_valid_m, 1'b0);

    // Test 3: backpressure on the 16th bit, then load-wins on consume
    word_ready = 1'b0;
    send_byte(8'hA5);
    check("t3_first_valid", word_valid_m, 1'b1);
    check("t3_first_word",  word_out_m,   8'hA5);
    send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    send_bit(1); send_bit(1); send_bit(0);
    check("t3_fill7",       fill_cnt_m,   3'd7);
    bit_valid = 1'b1; bit_in = 1'b0;
    #1;
    check("t3_ready_low",   bit_ready_m,  1'b0);
    tick(); tick();
    check("t3_word_held",   word_out_m,   8'hA5);
    check("t3_fill_held",   fill_cnt_m,   3'd7);
    word_ready = 1'b1;
    #1;
    check("t3_ready_high",  bit_ready_m,  1'b1);
    tick();
    bit_valid = 1'b0;
    check("t3_second_word", word_out_m,   8'h3C);
    check("t3_still_valid", word_valid_m, 1'b1);
    check("t3_fill_wrap",   fill_cnt_m,   3'd0);
    drain();
    check("t3_drained",     word_valid_m, 1'b0);

    // Test 4: clear discards partial bits and the bit accepted alongside it
    word_ready = 1'b1;
    send_bit(1); send_bit(0); send_bit(1);
    check("t4_fill3",       fill_cnt_m,   3'd3);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    clear = 1'b0; bit_valid = 1'b0;
    check("t4_cleared",     fill_cnt_m,   3'd0);
    check("t4_no_word",     word_valid_m, 1'b0);
    send_byte(8'hFF);
    check("t4_word_msb",    word_out_m,   8'hFF);
    check("t4_word_lsb",    word_out_l,   8'hFF);
    check("t4_fill",        fill_cnt_m,   3'd0);
    drain();

    // Test 5: asynchronous reset mid-word with a word held
    word_ready = 1'b0;
    send_byte(8'h5A);
    send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    check("t5_pre_valid",   word_valid_m, 1'b1);
    check("t5_pre_fill",    fill_cnt_m,   3'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid",   word_valid_m, 1'b0);
    check("t5_rst_word",    word_out_m,   8'h00);
    check("t5_rst_fill",    fill_cnt_m,   3'd0);
    tick();
    rst_n = 1'b1;
    send_byte(8'h81);
    check("t5_word_msb",    word_out_m,   8'h81);
    check("t5_word_lsb",    word_out_l,   8'h81);
    check("t5_valid",       word_valid_m, 1'b1);
    drain();
    check("t5_drained",     word_valid_m, 1'b0);

    // Test 6: random gaps and backpressure against a reference model
    tx = 8'($urandom); bidx = 0; consumed = 0; cycles = 0; m_wv = 1'b0;
    while (consumed < 1000 && cycles < 60000) begin
      cycles++;
      bit_valid  = 1'($urandom_range(0, 1));
      word_ready = 1'($urandom_range(0, 1));
      bit_in     = tx[3'(7 - bidx)];
      #1;
      m_rdy = !(bidx == 7 && m_wv && !word_ready);
      check("rnd_bit_ready",  bit_ready_m,  m_rdy);
      check("rnd_word_valid", word_valid_m, m_wv);
      if (m_wv && word_ready) begin
        check("rnd_word", word_out_m, exp_q.pop_front());
        consumed++;
        m_wv = 1'b0;
      end
      if (bit_valid && m_rdy) begin
        if (bidx == 7) begin
          exp_q.push_back(tx);
          m_wv = 1'b1;
          tx   = 8'($urandom);
          bidx = 0;
        end else begin
          bidx++;
        end
      end
      tick();
    end
    check("rnd_words_consumed", consumed, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
